ahb_subordinate_mem: RTL and testbench

Parametrised AHB subordinate memory model with HSIZE-aware byte-lane writes, LFSR-driven wait states, address and alignment checking with two-cycle ERROR responses, and a saturating fault counter. It sits on the subordinate side of the AHB bus in manager-level testbenches and FPGA bring-up builds. It replaces fixed-width, byte-only subordinate models and is synthesizable.

---
 rtl/ahb_subordinate_mem.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ahb_subordinate_mem.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_subordinate_mem.sv
// ---------------------------------------------------------------------------
// ahb_subordinate_mem
//
// Parametrised AHB subordinate memory. Byte-addressed storage of MEM_DEPTH
// bytes starting at BASE_ADDR, HSIZE-aware little-endian byte-lane writes,
// LFSR-driven wait states, decode/alignment checking with the two-cycle
// ERROR response, and a saturating count of completed non-OKAY responses.
//
// Optional feature macro: AHB_SUB_FAULT_INJECT_EN
//   When defined, valid accepted beats may be turned into RETRY
//   (lfsr[10:7]==0) or ERROR (lfsr[15:11]==0) responses; such beats use
//   the ERR1/ERR2 sequence and do not write memory.
//
// Ports:
//   i_hclk        bus clock, rising edge
//   i_hreset      asynchronous active-high reset
//   i_hsel        subordinate select
//   i_hready_in   bus HREADY, address phase accepted only when 1
//   i_haddr       byte address
//   i_htrans      IDLE/BUSY/NONSEQ/SEQ
//   i_hwrite      1 = write
//   i_hsize       log2 of transfer bytes
//   i_hburst      burst type (observed only)
//   i_hwdata      write data, data phase
//   o_hrdata      read data (combinational in DATA, 0 otherwise)
//   o_hready      transfer done
//   o_hresp       OKAY/ERROR/RETRY/SPLIT
//   o_err_cnt     saturating count of completed non-OKAY responses
// ---------------------------------------------------------------------------
module ahb_subordinate_mem #(
  parameter int unsigned DATA_WDT  = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned WAIT_WT   = 2,
  parameter int unsigned WAIT_MAX  = 4
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_hsel,
  input  logic                i_hready_in,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output logic [1:0]          o_hresp,
  output logic [15:0]         o_err_cnt
);

  localparam int unsigned NB     = DATA_WDT / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned AW     = $clog2(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
`ifdef AHB_SUB_FAULT_INJECT_EN
  localparam logic [1:0] RESP_RETRY = 2'b10;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [2:0]      size_q, size_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic [1:0]      resp_q, resp_d;
  logic [15:0]     err_cnt_q;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [7:0]      mem_q [MEM_DEPTH];

  logic [31:0]         offset_s;
  logic [7:0]          size_bytes_s;
  logic [31:0]         align_mask_s;
  logic                err_s;
  logic                accept_s;
  logic                wait_hit_s;
  logic [2:0]          wcnt_s;
  logic                hready_s;
  logic [1:0]          hresp_s;
  logic                commit_s;
  logic                take_s;
  logic [LANE_W-1:0]   lane_s;
  logic [AW-LANE_W-1:0] word_s;
  logic [7:0]          nbytes_s;
  logic [NB-1:0]       be_s;
  logic [DATA_WDT-1:0] rdata_s;
  logic                unused_s;

  // Burst type is observed only.
  assign unused_s = ^i_hburst;

  // Fibonacci LFSR, taps 16,14,13,11.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Address-phase decode: offset, decode/alignment/size error, wait count.
  always_comb begin
    offset_s     = i_haddr - BASE_ADDR;
    size_bytes_s = 8'd1 << i_hsize;
    align_mask_s = {24'd0, size_bytes_s - 8'd1};
    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    err_s        = (offset_s >= 32'(MEM_DEPTH))
                 | ((i_haddr & align_mask_s) != 32'd0)
                 | (size_bytes_s > 8'(NB));
    accept_s     = i_hsel & i_hready_in & i_htrans[1];
    wait_hit_s   = {1'b0, lfsr_q[2:0]} < 4'(WAIT_WT);
    if (!wait_hit_s) begin
      wcnt_s = 3'd0;
    end else if (lfsr_q[5:3] > 3'(WAIT_MAX)) begin
      wcnt_s = 3'(WAIT_MAX);
    end else begin
      wcnt_s = lfsr_q[5:3];
    end
  end

  // Next-state and bus response logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    wcnt_d   = wcnt_q;
    resp_d   = resp_q;
    hready_s = 1'b1;
    hresp_s  = RESP_OKAY;
    commit_s = 1'b0;
    take_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        take_s = 1'b1;
      end
      ST_WAIT: begin
        hready_s = 1'b0;
        // k waits: the cycle that sees count 1 is the last wait cycle.
        if (wcnt_q <= 3'd1) begin
          state_d = ST_DATA;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      ST_DATA: begin
        commit_s = write_q;
        take_s   = 1'b1;
      end
      ST_ERR1: begin
        hready_s = 1'b0;
        hresp_s  = resp_q;
        state_d  = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_s = resp_q;
        take_s  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any cycle with HREADY high samples a new address phase.
    if (take_s) begin
      if (accept_s) begin
        addr_d  = offset_s[AW-1:0];
        write_d = i_hwrite;
        size_d  = i_hsize;
        wcnt_d  = wcnt_s;
        resp_d  = RESP_ERROR;
        if (err_s) begin
          state_d = ST_ERR1;
        end
`ifdef AHB_SUB_FAULT_INJECT_EN
        else if (lfsr_q[10:7] == 4'd0) begin
          resp_d  = RESP_RETRY;
          state_d = ST_ERR1;
        end else if (lfsr_q[15:11] == 5'd0) begin
          resp_d  = RESP_ERROR;
          state_d = ST_ERR1;
        end
`endif
        else if (wcnt_s == 3'd0) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_WAIT;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      // Mid-transfer: the case statement above already chose the next state.
      state_d = state_d;
    end
  end

  // Byte-lane enables and read word selection for the current data phase.
  always_comb begin
    lane_s   = addr_q[LANE_W-1:0];
    word_s   = addr_q[AW-1:LANE_W];
    nbytes_s = 8'd1 << size_q;
    be_s     = '0;
    rdata_s  = '0;
    for (int l = 0; l < int'(NB); l++) begin
      be_s[l] = (8'(l) >= 8'(lane_s)) && (8'(l) < (8'(lane_s) + nbytes_s));
    end
    if (state_q == ST_DATA) begin
      for (int l = 0; l < int'(NB); l++) begin
        rdata_s[l*8 +: 8] = mem_q[{word_s, LANE_W'(l)}];
      end
    end else begin
      rdata_s = '0;
    end
  end

  assign o_hready  = hready_s;
  assign o_hresp   = hresp_s;
  assign o_hrdata  = rdata_s;
  assign o_err_cnt = err_cnt_q;

  // Control state, latched address phase and LFSR.
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      wcnt_q  <= 3'd0;
      resp_q  <= RESP_OKAY;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wcnt_q  <= wcnt_d;
      resp_q  <= resp_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Saturating count of completed non-OKAY responses (counted on leaving ERR2).
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      err_cnt_q <= 16'd0;
    end else if ((state_q == ST_ERR2) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  // Memory array: cleared on reset, written at the closing edge of a DATA write.
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= 8'd0;
      end
    end else if (commit_s) begin
      for (int l = 0; l < int'(NB); l++) begin
        if (be_s[l]) begin
          mem_q[{word_s, LANE_W'(l)}] <= i_hwdata[l*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
`timescale 1ns/1ps
module tb_ahb_subordinate_mem;

  localparam int          DW    = 32;
  localparam int          NB    = DW / 8;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          WT    = 3;
  localparam int          WMAX  = 4;

  logic          i_hclk, i_hreset, i_hsel, i_hready_in, i_hwrite;
  logic [31:0]   i_haddr;
  logic [1:0]    i_htrans;
  logic [2:0]    i_hsize, i_hburst;
  logic [DW-1:0] i_hwdata;
  logic [DW-1:0] o_hrdata;
  logic          o_hready;
  logic [1:0]    o_hresp;
  logic [15:0]   o_err_cnt;

  ahb_subordinate_mem #(
    .DATA_WDT(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE),
    .LFSR_SEED(SEED), .WAIT_WT(WT), .WAIT_MAX(WMAX)
  ) dut (
    .i_hclk(i_hclk), .i_hreset(i_hreset), .i_hsel(i_hsel),
    .i_hready_in(i_hready_in), .i_haddr(i_haddr), .i_htrans(i_htrans),
    .i_hwrite(i_hwrite), .i_hsize(i_hsize), .i_hburst(i_hburst),
    .i_hwdata(i_hwdata), .o_hrdata(o_hrdata), .o_hready(o_hready),
    .o_hresp(o_hresp), .o_err_cnt(o_err_cnt)
  );

  initial begin
    i_hclk = 1'b0;
    forever #5 i_hclk = ~i_hclk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // kind_m: 0 no data phase, 1 good beat, 2 error beat
  logic [7:0]  mem_m [DEPTH];
  logic [15:0] lfsr_m;
  int          kind_m, wait_m, eph_m, sz_m, errcnt_m;
  int unsigned off_m;
  bit          wr_m;

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'd0;
    lfsr_m = SEED; kind_m = 0; wait_m = 0; eph_m = 0; sz_m = 0;
    errcnt_m = 0; off_m = 0; wr_m = 1'b0;
  endtask

  function automatic logic [31:0] m_word(input int unsigned off);
    logic [31:0] w;
    int unsigned b;
    b = off - (off % NB);
    for (int j = 0; j < NB; j++) w[j*8 +: 8] = mem_m[b + j];
    return w;
  endfunction

  function automatic bit m_ready();
    if (kind_m == 2) return (eph_m == 1);
    if (kind_m == 1) return (wait_m == 0);
    return 1'b1;
  endfunction

  task automatic m_step();
    logic [31:0] off32;
    int          szb, fb, lane, w3;
    if (m_ready()) begin
      if (kind_m == 1 && wr_m) begin
        lane = off_m % NB;
        for (int j = 0; j < (1 << sz_m); j++)
          mem_m[off_m + j] = i_hwdata[(lane + j)*8 +: 8];
      end
      if (kind_m == 2 && errcnt_m < 65535) errcnt_m++;
      if (i_hsel && i_hready_in && (i_htrans == 2'b10 || i_htrans == 2'b11)) begin
        off32 = i_haddr - BASE;
        szb   = 1 << i_hsize;
        if (off32 >= DEPTH || (i_haddr & (szb - 1)) != 0 || szb > NB) begin
          kind_m = 2; eph_m = 0;
        end else begin
          kind_m = 1; off_m = off32; wr_m = i_hwrite; sz_m = int'(i_hsize);
          w3 = (lfsr_m >> 3) & 7;
          if ((lfsr_m & 7) < WT) wait_m = (w3 > WMAX) ? WMAX : w3;
          else wait_m = 0;
        end
      end else begin
        kind_m = 0;
      end
    end else if (kind_m == 2) begin
      eph_m = 1;
    end else begin
      wait_m--;
    end
    fb = ((lfsr_m >> 15) ^ (lfsr_m >> 13) ^ (lfsr_m >> 12) ^ (lfsr_m >> 10)) & 1;
    lfsr_m = 16'(((lfsr_m << 1) | fb) & 16'hFFFF);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge i_hclk or posedge i_hreset);
      if (i_hreset) m_reset();
      else m_step();
    end
  end

  // Per-cycle compare of DUT outputs against the model.
  initial begin
    logic [31:0] e_rd;
    bit          e_rdy;
    logic [1:0]  e_resp;
    forever begin
      @(negedge i_hclk);
      e_rdy = m_ready(); e_resp = 2'b00; e_rd = 32'd0;
      if (kind_m == 2) e_resp = 2'b01;
      else if (kind_m == 1 && wait_m == 0 && !wr_m) e_rd = m_word(off_m);
      chk("hready", {31'd0, o_hready}, {31'd0, e_rdy});
      chk("hresp", {30'd0, o_hresp}, {30'd0, e_resp});
      if (!(kind_m == 1 && wait_m == 0 && wr_m)) chk("hrdata", o_hrdata, e_rd);
      chk("err_cnt", {16'd0, o_err_cnt}, errcnt_m);
    end
  end

  // ---------------- pipelined master ----------------
  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  burst;
  } beat_t;

  beat_t       q[$];
  logic [31:0] rd_res[$];
  int          err_cyc;

  function automatic beat_t mk(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [1:0] tr, input logic [2:0] bu);
    beat_t b;
    b.sel = 1'b1; b.trans = tr; b.wr = wr; b.sz = sz; b.addr = addr; b.wdata = wd; b.burst = bu;
    return b;
  endfunction

  task automatic drive_idle();
    i_hsel = 1'b0; i_htrans = 2'b00; i_hwrite = 1'b0; i_hsize = 3'd0;
    i_haddr = 32'd0; i_hburst = 3'd0;
  endtask

  task automatic run_q();
    beat_t       d;
    bit          have_d, rdy;
    logic [31:0] rdv;
    int          cyc, maxc;
    have_d = 1'b0; cyc = 0; maxc = q.size() * 12 + 20; err_cyc = 0;
    while ((q.size() > 0 || have_d) && cyc < maxc) begin
      if (q.size() > 0) begin
        i_hsel = q[0].sel; i_htrans = q[0].trans; i_hwrite = q[0].wr;
        i_hsize = q[0].sz; i_haddr = q[0].addr; i_hburst = q[0].burst;
      end else begin
        drive_idle();
      end
      i_hwdata = have_d ? d.wdata : 32'h5A5A_5A5A;
      @(negedge i_hclk);
      rdy = o_hready; rdv = o_hrdata;
      if (o_hresp == 2'b01) err_cyc++;
      @(posedge i_hclk); #1;
      cyc++;
      if (rdy) begin
        if (have_d && !d.wr) rd_res.push_back(rdv);
        have_d = 1'b0;
        if (q.size() > 0) begin
          d = q.pop_front();
          have_d = d.sel && d.trans[1];
        end
      end
    end
    total++;
    if (cyc >= maxc) begin
      bad++;
      $display("FAIL run_timeout got=%0d want<%0d", cyc, maxc);
      q.delete();
    end
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          got;
    int          r, sz;
    int unsigned off;
    beat_t       b;
    logic [31:0] wd [8];

    i_hreset = 1'b1; i_hready_in = 1'b1; i_hwdata = 32'd0;
    drive_idle();
    repeat (3) @(negedge i_hclk);
    chk("rst_hready", {31'd0, o_hready}, 32'd1);
    chk("rst_hresp", {30'd0, o_hresp}, 32'd0);
    chk("rst_hrdata", o_hrdata, 32'd0);
    chk("rst_errcnt", {16'd0, o_err_cnt}, 32'd0);
    #2 i_hreset = 1'b0;
    @(posedge i_hclk); #1;

    // Word write then read-back.
    rd_res.delete();
    q.push_back(mk(1, 3'd2, 32'h100, 32'hDEADBEEF, 2'b10, 3'd0));
    q.push_back(mk(0, 3'd2, 32'h100, 32'h0, 2'b10, 3'd0));
    run_q();
    chk("w32_read", rd_res.size() > 0 ? rd_res[0] : 32'hX, 32'hDEADBEEF);

    // Byte write into a zero word: only lane 2 may change.
    rd_res.delete();
    q.push_back(mk(1, 3'd0, 32'h106, 32'h11A52233, 2'b10, 3'd0));
    q.push_back(mk(0, 3'd2, 32'h104, 32'h0, 2'b10, 3'd0));
    run_q();
    chk("byte_lane", rd_res.size() > 0 ? rd_res[0] : 32'hX, 32'h00A50000);

    // Out-of-range access: two error cycles, counter to 1.
    q.push_back(mk(1, 3'd2, BASE + DEPTH, 32'hFFFFFFFF, 2'b10, 3'd0));
    run_q();
    chk("oor_errcyc", err_cyc, 32'd2);
    chk("oor_errcnt", {16'd0, o_err_cnt}, 32'd1);

    // Misaligned word, then a pipelined read accepted in ERR2.
    rd_res.delete();
    q.push_back(mk(1, 3'd2, 32'h101, 32'h12345678, 2'b10, 3'd0));
    q.push_back(mk(0, 3'd2, 32'h100, 32'h0, 2'b10, 3'd0));
    run_q();
    chk("misal_errcyc", err_cyc, 32'd2);
    chk("misal_next", rd_res.size() > 0 ? rd_res[0] : 32'hX, 32'hDEADBEEF);
    chk("misal_errcnt", {16'd0, o_err_cnt}, 32'd2);

    // HREADY_IN low: address phase must be ignored.
    i_hready_in = 1'b0; i_hsel = 1'b1; i_htrans = 2'b10; i_hwrite = 1'b1;
    i_hsize = 3'd2; i_haddr = 32'h108;
    @(posedge i_hclk); #1;
    i_hready_in = 1'b1; drive_idle(); i_hwdata = 32'hFFFFFFFF;
    @(posedge i_hclk); #1;
    rd_res.delete();
    q.push_back(mk(0, 3'd2, 32'h108, 32'h0, 2'b10, 3'd0));
    run_q();
    chk("hrin_low", rd_res.size() > 0 ? rd_res[0] : 32'hX, 32'h0);

    // INCR8 write then read-back.
    for (int i = 0; i < 8; i++) begin
      wd[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      q.push_back(mk(1, 3'd2, 32'h140 + 32'(4*i), wd[i], i == 0 ? 2'b10 : 2'b11, 3'b101));
    end
    run_q();
    rd_res.delete();
    for (int i = 0; i < 8; i++)
      q.push_back(mk(0, 3'd2, 32'h140 + 32'(4*i), 32'h0, i == 0 ? 2'b10 : 2'b11, 3'b101));
    run_q();
    chk("burst_cnt", rd_res.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      chk("burst_data", i < rd_res.size() ? rd_res[i] : 32'hX, wd[i]);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      b.sel = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 19);
      b.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 10) ? 2'b10 : 2'b11;
      b.wr = $urandom_range(0, 1);
      r = $urandom_range(0, 19);
      sz = (r == 0) ? 3 : (r < 6) ? 0 : (r < 11) ? 1 : 2;
      b.sz = 3'(sz);
      off = $urandom_range(0, DEPTH + 15);
      if ($urandom_range(0, 9) != 0) off = off & ~((32'd1 << sz) - 32'd1);
      b.addr = BASE + off;
      if ($urandom_range(0, 29) == 0) b.addr = $urandom_range(0, 32'hFF);
      b.wdata = $urandom;
      b.burst = 3'(($urandom_range(0, 7)));
      q.push_back(b);
    end
    run_q();
    for (int i = 0; i < DEPTH / NB; i++)
      q.push_back(mk(0, 3'd2, BASE + 32'(4*i), 32'h0, 2'b10, 3'd0));
    run_q();

    // Reset during a WAIT cycle of a write.
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      i_hsel = 1'b1; i_htrans = 2'b10; i_hwrite = 1'b1; i_hsize = 3'd2; i_haddr = 32'h180;
      @(posedge i_hclk); #1;
      drive_idle(); i_hwdata = 32'hCAFEF00D;
      @(negedge i_hclk);
      if (o_hready === 1'b0) begin
        #1 i_hreset = 1'b1; got = 1'b1;
        @(negedge i_hclk);
        chk("rstw_hready", {31'd0, o_hready}, 32'd1);
        chk("rstw_hresp", {30'd0, o_hresp}, 32'd0);
        #2 i_hreset = 1'b0;
      end else begin
        for (int k = 0; k < 8 && o_hready !== 1'b1; k++) @(negedge i_hclk);
      end
      @(posedge i_hclk); #1;
    end
    chk("rstw_seen", {31'd0, got}, 32'd1);
    rd_res.delete();
    q.push_back(mk(0, 3'd2, 32'h180, 32'h0, 2'b10, 3'd0));
    run_q();
    chk("rstw_read", rd_res.size() > 0 ? rd_res[0] : 32'hX, 32'h0);
    chk("rstw_errcnt", {16'd0, o_err_cnt}, 32'd0);

    repeat (2) @(posedge i_hclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
